// File: rtl/cache_bus_arbiter_pkg.sv
// Shared definitions for the cache bus arbiter: state codes, owner encoding,
// burst constants and the line-alignment helper.
package cpu_defs;

  localparam int LINE_WORDS_DEF = 8;
  localparam logic [7:0] BURST_LEN = 8'(LINE_WORDS_DEF - 1);

  typedef logic [2:0] arbState_t;

  localparam arbState_t ST_IDLE    = 3'd0;
  localparam arbState_t ST_RD_ADDR = 3'd1;
  localparam arbState_t ST_RD_DATA = 3'd2;
  localparam arbState_t ST_WR_ADDR = 3'd3;
  localparam arbState_t ST_WR_DATA = 3'd4;
  localparam arbState_t ST_WR_RESP = 3'd5;
  localparam arbState_t ST_DONE    = 3'd6;

  typedef enum logic [1:0] {
    OWN_I  = 2'd0,
    OWN_DR = 2'd1,
    OWN_DW = 2'd2
  } arbOwner_e;

  // Clears the byte-in-word and word-in-line bits so bursts start on a line.
  function automatic logic [31:0] lineAlign(input logic [31:0] addr, input int idxW);
    logic [31:0] mask;
    mask = ~((32'd1 << (idxW + 2)) - 32'd1);
    return addr & mask;
  endfunction

endpackage

// File: rtl/cache_bus_arbiter_if.sv
// Memory-side AXI-style burst port shared by the caches; the arbiter is the
// master, the top-level bus interface (or a memory model) is the slave.
interface cache_bus_arbiter_if;

  logic        m_ar_valid;
  logic        m_ar_ready;
  logic [31:0] m_ar_addr;
  logic [7:0]  m_ar_len;

  logic        m_r_valid;
  logic        m_r_ready;
  logic [31:0] m_r_data;
  logic        m_r_last;

  logic        m_aw_valid;
  logic        m_aw_ready;
  logic [31:0] m_aw_addr;
  logic [7:0]  m_aw_len;

  logic        m_w_valid;
  logic        m_w_ready;
  logic [31:0] m_w_data;
  logic        m_w_last;

  logic        m_b_valid;
  logic        m_b_ready;

  modport master (
    output m_ar_valid, m_ar_addr, m_ar_len,
    input  m_ar_ready,
    input  m_r_valid, m_r_data, m_r_last,
    output m_r_ready,
    output m_aw_valid, m_aw_addr, m_aw_len,
    input  m_aw_ready,
    output m_w_valid, m_w_data, m_w_last,
    input  m_w_ready,
    input  m_b_valid,
    output m_b_ready
  );

  modport slave (
    input  m_ar_valid, m_ar_addr, m_ar_len,
    output m_ar_ready,
    output m_r_valid, m_r_data, m_r_last,
    input  m_r_ready,
    input  m_aw_valid, m_aw_addr, m_aw_len,
    output m_aw_ready,
    input  m_w_valid, m_w_data, m_w_last,
    output m_w_ready,
    output m_b_valid,
    input  m_b_ready
  );

endinterface

// File: rtl/cache_bus_arbiter_pick.sv
// Combinational priority picker: starved I-cache, then writeback, then
// D refill, then I refill.
module cache_arb_pick
  import cpu_defs::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic             iReq,
  input  logic             drReq,
  input  logic             dwReq,
  input  logic [CNT_W-1:0] starveCnt,
  output logic             valid,
  output arbOwner_e        owner
);

  always_comb begin
    valid = 1'b1;
    owner = OWN_I;
    if (iReq && (starveCnt == CNT_W'(STARVE_LIMIT))) begin
      owner = OWN_I;
    end else if (dwReq) begin
      // Dirty victim must reach memory before its replacement line is read.
      owner = OWN_DW;
    end else if (drReq) begin
      owner = OWN_DR;
    end else if (iReq) begin
      owner = OWN_I;
    end else begin
      valid = 1'b0;
    end
  end

endmodule

// File: rtl/cache_bus_arbiter.sv
// Serializes I-refill, D-refill and D-writeback line bursts onto the single
// memory port, one transaction at a time.
module cache_bus_arbiter
  import cpu_defs::*;
#(
  parameter int LINE_WORDS   = LINE_WORDS_DEF,
  parameter int IDX_W        = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             resetn,

  input  logic             i_rd_req,
  input  logic [31:0]      i_rd_addr,
  output logic             i_rvalid,
  output logic             i_rlast,

  input  logic             d_rd_req,
  input  logic [31:0]      d_rd_addr,
  output logic             d_rvalid,
  output logic             d_rlast,

  output logic [31:0]      rdata,

  input  logic             d_wr_req,
  input  logic [31:0]      d_wr_addr,
  output logic [IDX_W-1:0] d_wr_idx,
  input  logic [31:0]      d_wr_data,
  output logic             d_wr_done,

  cache_bus_arbiter_if.master bus,

  output logic             busy
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);
  localparam logic [7:0] LEN = 8'(LINE_WORDS - 1);

  arbState_t        stateReg, stateNext;
  arbOwner_e        ownerReg, ownerNext;
  logic [31:0]      addrReg, addrNext;
  logic [IDX_W-1:0] cntReg, cntNext;
  logic [CNT_W-1:0] starveCntReg, starveCntNext;

  logic             pickValid;
  arbOwner_e        pickOwner;
  logic [31:0]      reqAddr;

  cache_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_pick (
    .iReq      (i_rd_req),
    .drReq     (d_rd_req),
    .dwReq     (d_wr_req),
    .starveCnt (starveCntReg),
    .valid     (pickValid),
    .owner     (pickOwner)
  );

  always_comb begin
    case (pickOwner)
      OWN_DR:  reqAddr = d_rd_addr;
      OWN_DW:  reqAddr = d_wr_addr;
      default: reqAddr = i_rd_addr;
    endcase
  end

  always_comb begin
    stateNext     = stateReg;
    ownerNext     = ownerReg;
    addrNext      = addrReg;
    cntNext       = cntReg;
    starveCntNext = starveCntReg;

    case (stateReg)
      ST_IDLE: begin
        if (!i_rd_req) begin
          starveCntNext = '0;
        end
        if (pickValid) begin
          ownerNext = pickOwner;
          addrNext  = lineAlign(reqAddr, IDX_W);
          if (pickOwner == OWN_I) begin
            starveCntNext = '0;
          end else if (i_rd_req && (starveCntReg != CNT_W'(STARVE_LIMIT))) begin
            starveCntNext = starveCntReg + 1'b1;
          end
          stateNext = (pickOwner == OWN_DW) ? ST_WR_ADDR : ST_RD_ADDR;
        end
      end

      ST_RD_ADDR: begin
        if (bus.m_ar_ready) begin
          stateNext = ST_RD_DATA;
        end
      end

      ST_RD_DATA: begin
        if (bus.m_r_valid && bus.m_r_last) begin
          stateNext = ST_DONE;
        end
      end

      ST_WR_ADDR: begin
        if (bus.m_aw_ready) begin
          stateNext = ST_WR_DATA;
          cntNext   = '0;
        end
      end

      ST_WR_DATA: begin
        if (bus.m_w_ready) begin
          if (cntReg == LAST_IDX) begin
            stateNext = ST_WR_RESP;
          end else begin
            cntNext = cntReg + 1'b1;
          end
        end
      end

      ST_WR_RESP: begin
        if (bus.m_b_valid) begin
          stateNext = ST_DONE;
        end
      end

      // One dead cycle lets the finished requester drop its level request.
      ST_DONE: stateNext = ST_IDLE;

      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      stateReg     <= ST_IDLE;
      ownerReg     <= OWN_I;
      addrReg      <= '0;
      cntReg       <= '0;
      starveCntReg <= '0;
    end else begin
      stateReg     <= stateNext;
      ownerReg     <= ownerNext;
      addrReg      <= addrNext;
      cntReg       <= cntNext;
      starveCntReg <= starveCntNext;
    end
  end

  logic inRdAddr, inRdData, inWrAddr, inWrData, inWrResp;

  assign inRdAddr = (stateReg == ST_RD_ADDR);
  assign inRdData = (stateReg == ST_RD_DATA);
  assign inWrAddr = (stateReg == ST_WR_ADDR);
  assign inWrData = (stateReg == ST_WR_DATA);
  assign inWrResp = (stateReg == ST_WR_RESP);

  // Bus-facing values are gated by their phase so an idle arbiter drives all zeros.
  assign bus.m_ar_valid = inRdAddr;
  assign bus.m_ar_addr  = inRdAddr ? addrReg : '0;
  assign bus.m_ar_len   = inRdAddr ? LEN : '0;
  assign bus.m_r_ready  = inRdData;

  assign bus.m_aw_valid = inWrAddr;
  assign bus.m_aw_addr  = inWrAddr ? addrReg : '0;
  assign bus.m_aw_len   = inWrAddr ? LEN : '0;
  assign bus.m_w_valid  = inWrData;
  assign bus.m_w_data   = inWrData ? d_wr_data : '0;
  assign bus.m_w_last   = inWrData && (cntReg == LAST_IDX);
  assign bus.m_b_ready  = inWrResp;

  assign i_rvalid  = inRdData && (ownerReg == OWN_I) && bus.m_r_valid;
  assign i_rlast   = i_rvalid && bus.m_r_last;
  assign d_rvalid  = inRdData && (ownerReg == OWN_DR) && bus.m_r_valid;
  assign d_rlast   = d_rvalid && bus.m_r_last;
  assign rdata     = inRdData ? bus.m_r_data : '0;

  assign d_wr_idx  = inWrData ? cntReg : '0;
  assign d_wr_done = inWrResp && bus.m_b_valid;

  assign busy = (stateReg != ST_IDLE);

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed bench for cache_bus_arbiter: refill, writeback ordering, write
// stalls, I-cache starvation guard and mid-burst reset.
module tb_cache_bus_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        i_rd_req = 1'b0;
  logic [31:0] i_rd_addr = '0;
  logic        i_rvalid, i_rlast;
  logic        d_rd_req = 1'b0;
  logic [31:0] d_rd_addr = '0;
  logic        d_rvalid, d_rlast;
  logic [31:0] rdata;
  logic        d_wr_req = 1'b0;
  logic [31:0] d_wr_addr = '0;
  logic [2:0]  d_wr_idx;
  logic [31:0] d_wr_data;
  logic        d_wr_done;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_bus_arbiter_if bus();

  cache_bus_arbiter #(
    .LINE_WORDS   (8),
    .IDX_W        (3),
    .STARVE_LIMIT (4)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .i_rd_req  (i_rd_req),
    .i_rd_addr (i_rd_addr),
    .i_rvalid  (i_rvalid),
    .i_rlast   (i_rlast),
    .d_rd_req  (d_rd_req),
    .d_rd_addr (d_rd_addr),
    .d_rvalid  (d_rvalid),
    .d_rlast   (d_rlast),
    .rdata     (rdata),
    .d_wr_req  (d_wr_req),
    .d_wr_addr (d_wr_addr),
    .d_wr_idx  (d_wr_idx),
    .d_wr_data (d_wr_data),
    .d_wr_done (d_wr_done),
    .bus       (bus.master),
    .busy      (busy)
  );

  // D-cache line buffer model: word k of the victim line is 0xB0+k.
  assign d_wr_data = 32'hB0 + 32'(d_wr_idx);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, " ctl"}, 32'({busy, i_rvalid, i_rlast, d_rvalid, d_rlast, d_wr_done,
                            bus.m_ar_valid, bus.m_r_ready, bus.m_aw_valid,
                            bus.m_w_valid, bus.m_w_last, bus.m_b_ready}), 32'd0);
    chk({tag, " ar_addr"}, bus.m_ar_addr, 32'd0);
    chk({tag, " aw_addr"}, bus.m_aw_addr, 32'd0);
    chk({tag, " lens"}, 32'({bus.m_ar_len, bus.m_aw_len}), 32'd0);
    chk({tag, " rdata"}, rdata, 32'd0);
    chk({tag, " w_data"}, bus.m_w_data, 32'd0);
    chk({tag, " wr_idx"}, 32'(d_wr_idx), 32'd0);
  endtask

  task automatic readBurst(input string tag, input bit toI, input logic [31:0] expAddr,
                           input logic [31:0] base);
    for (int k = 0; k < 16; k++) begin
      if (bus.m_ar_valid) break;
      adv();
    end
    chkBit({tag, " ar_valid"}, bus.m_ar_valid, 1'b1);
    chk({tag, " ar_addr"}, bus.m_ar_addr, expAddr);
    chk({tag, " ar_len"}, 32'(bus.m_ar_len), 32'd7);
    chkBit({tag, " aw_valid"}, bus.m_aw_valid, 1'b0);
    bus.m_ar_ready = 1'b1;
    adv();
    bus.m_ar_ready = 1'b0;
    for (int b = 0; b < 8; b++) begin
      bus.m_r_valid = 1'b1;
      bus.m_r_data  = base + 32'(b);
      bus.m_r_last  = (b == 7);
      #1;
      chkBit({tag, " r_ready"}, bus.m_r_ready, 1'b1);
      chkBit({tag, " i_rvalid"}, i_rvalid, toI);
      chkBit({tag, " d_rvalid"}, d_rvalid, !toI);
      chkBit({tag, " i_rlast"}, i_rlast, toI && (b == 7));
      chkBit({tag, " d_rlast"}, d_rlast, !toI && (b == 7));
      chk({tag, " rdata"}, rdata, base + 32'(b));
      adv();
    end
    bus.m_r_valid = 1'b0;
    bus.m_r_last  = 1'b0;
    bus.m_r_data  = '0;
    $display("read burst %s owner=%s addr=%h", tag, toI ? "I" : "D", expAddr);
  endtask

  task automatic writeBurst(input string tag, input bit toggle, input logic [31:0] expAddr);
    int beats;
    beats = 0;
    for (int k = 0; k < 16; k++) begin
      if (bus.m_aw_valid) break;
      adv();
    end
    chkBit({tag, " aw_valid"}, bus.m_aw_valid, 1'b1);
    chkBit({tag, " ar_valid"}, bus.m_ar_valid, 1'b0);
    chk({tag, " aw_addr"}, bus.m_aw_addr, expAddr);
    chk({tag, " aw_len"}, 32'(bus.m_aw_len), 32'd7);
    bus.m_aw_ready = 1'b1;
    adv();
    bus.m_aw_ready = 1'b0;
    for (int c = 0; c < 32 && beats < 8; c++) begin
      bus.m_w_ready = toggle ? (c % 2 == 0) : 1'b1;
      #1;
      chkBit({tag, " w_valid"}, bus.m_w_valid, 1'b1);
      chk({tag, " wr_idx"}, 32'(d_wr_idx), 32'(beats));
      chk({tag, " w_data"}, bus.m_w_data, 32'hB0 + 32'(beats));
      chkBit({tag, " w_last"}, bus.m_w_last, beats == 7);
      if (bus.m_w_ready) beats++;
      adv();
    end
    bus.m_w_ready = 1'b0;
    #1;
    chkBit({tag, " w_valid after 8"}, bus.m_w_valid, 1'b0);
    chkBit({tag, " b_ready"}, bus.m_b_ready, 1'b1);
    chkBit({tag, " done early"}, d_wr_done, 1'b0);
    adv();
    chkBit({tag, " b_ready held"}, bus.m_b_ready, 1'b1);
    bus.m_b_valid = 1'b1;
    #1;
    chkBit({tag, " wr_done"}, d_wr_done, 1'b1);
    adv();
    bus.m_b_valid = 1'b0;
    #1;
    chkBit({tag, " wr_done pulse"}, d_wr_done, 1'b0);
    chkBit({tag, " busy in DONE"}, busy, 1'b1);
    $display("write burst %s addr=%h stall=%0d", tag, expAddr, toggle);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.m_ar_ready = 1'b0;
    bus.m_r_valid  = 1'b0;
    bus.m_r_data   = '0;
    bus.m_r_last   = 1'b0;
    bus.m_aw_ready = 1'b0;
    bus.m_w_ready  = 1'b0;
    bus.m_b_valid  = 1'b0;

    // Reset state
    adv(); adv(); adv();
    chkAllZero("reset");
    resetn = 1'b1;
    adv();
    chk("reset starve", 32'(dut.starveCntReg), 32'd0);

    // Lone I-cache refill, unaligned address
    i_rd_addr = 32'h1FC0_0014;
    i_rd_req  = 1'b1;
    readBurst("t1", 1'b1, 32'h1FC0_0000, 32'hA0);
    i_rd_req = 1'b0;
    #1;
    chkBit("t1 busy DONE", busy, 1'b1);
    adv();
    chkBit("t1 busy IDLE", busy, 1'b0);

    // Writeback and refill together: write first, then refill after DONE+IDLE
    d_wr_addr = 32'h0000_4024;
    d_rd_addr = 32'h0000_5008;
    d_wr_req  = 1'b1;
    d_rd_req  = 1'b1;
    adv();
    writeBurst("t2", 1'b0, 32'h0000_4020);
    d_wr_req = 1'b0;
    #1;
    chkBit("t2 ar_valid DONE", bus.m_ar_valid, 1'b0);
    adv();
    chkBit("t2 ar_valid IDLE", bus.m_ar_valid, 1'b0);
    adv();
    chkBit("t2 ar_valid rise", bus.m_ar_valid, 1'b1);
    readBurst("t2 rd", 1'b0, 32'h0000_5000, 32'hC0);
    d_rd_req = 1'b0;
    adv();
    adv();

    // Write data stalls with m_w_ready toggling 1,0,1,0
    d_wr_addr = 32'h0000_6000;
    d_wr_req  = 1'b1;
    writeBurst("t3", 1'b1, 32'h0000_6000);
    d_wr_req = 1'b0;
    adv();
    adv();

    // Starvation guard: four D grants, then I wins despite d_rd_req
    i_rd_addr = 32'h0000_1040;
    d_rd_addr = 32'h0000_2084;
    i_rd_req  = 1'b1;
    d_rd_req  = 1'b1;
    for (int n = 0; n < 4; n++) begin
      readBurst("t4 D", 1'b0, 32'h0000_2080, 32'h10 * 32'(n));
      chk("t4 starve", 32'(dut.starveCntReg), 32'(n + 1));
    end
    readBurst("t4 I", 1'b1, 32'h0000_1040, 32'hE0);
    chk("t4 starve cleared", 32'(dut.starveCntReg), 32'd0);
    i_rd_req = 1'b0;
    d_rd_req = 1'b0;
    adv();
    adv();

    // Reset during RD_DATA beat 3
    i_rd_addr = 32'h3000_0044;
    i_rd_req  = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (bus.m_ar_valid) break;
      adv();
    end
    chk("t5 ar_addr", bus.m_ar_addr, 32'h3000_0040);
    bus.m_ar_ready = 1'b1;
    adv();
    bus.m_ar_ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      bus.m_r_valid = 1'b1;
      bus.m_r_data  = 32'h70 + 32'(b);
      if (b == 2) resetn = 1'b0;
      #1;
      chkBit("t5 i_rvalid", i_rvalid, 1'b1);
      adv();
    end
    bus.m_r_valid = 1'b0;
    bus.m_r_data  = '0;
    i_rd_req      = 1'b0;
    #1;
    chkAllZero("t5 after reset");
    resetn = 1'b1;
    adv();
    chkAllZero("t5 idle");
    i_rd_addr = 32'h3000_0100;
    i_rd_req  = 1'b1;
    readBurst("t5 new", 1'b1, 32'h3000_0100, 32'h50);
    i_rd_req = 1'b0;
    adv();
    chkBit("t5 final busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
